// File: rtl/alu_shift_add_mult.sv
// rtl/alu_shift_add_mult.sv - multi-cycle unsigned shift-and-add multiplier
`timescale 1ns/1ps
module alu_shift_add_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Partial-product add; the carry-out becomes the top bit of the shifted accumulator.
  assign w_addend      = r_mplier[0] ? r_mcand : '0;
  assign {w_co, w_sum} = {1'b0, w_addend} + {1'b0, r_acc_hi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= A;
      r_mplier <= B;
      r_acc_hi <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      {r_acc_hi, r_mplier} <= {w_co, w_sum, r_mplier[WIDTH-1:1]};
      r_cnt                <= r_cnt + CW'(1);
    end
  end

  assign P = {r_acc_hi, r_mplier};

endmodule

// File: tb/tb_alu_shift_add_mult.sv
// tb/tb_alu_shift_add_mult.sv - directed-vector bench for alu_shift_add_mult
`timescale 1ns/1ps
module tb_alu_shift_add_mult;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   A = '0;
  logic [WIDTH-1:0]   B = '0;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] P;

  int n_tests = 0;
  int n_fail  = 0;

  alu_shift_add_mult #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge that sampled start; counts edges until done, bounded.
  task automatic wait_done(input int glitch_at, output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (glitch_at >= 0 && n == glitch_at) begin
        start = 1'b1;
        A = 16'd2;
        B = 16'd2;
      end else if (glitch_at >= 0 && n == glitch_at + 1) begin
        start = 1'b0;
      end
      step();
      n++;
    end
  endtask

  task automatic mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input int glitch_at);
    int n, nb;
    A = a;
    B = b;
    start = 1'b1;
    step();
    start = 1'b0;
    A = 16'hA5A5;
    B = 16'h5A5A;
    wait_done(glitch_at, n, nb);
    check({tag, " latency"}, 64'(n), 64'(WIDTH));
    check({tag, " busy cycles"}, 64'(nb), 64'(WIDTH));
    check({tag, " P"}, 64'(P), 64'(exp));
    step();
    check({tag, " idle after"}, {62'd0, busy, done}, 64'd0);
    check({tag, " P held"}, 64'(P), 64'(exp));
  endtask

  initial begin
    int n, nb;

    rst = 1'b1;
    #12;
    check("reset outputs", {30'd0, busy, done, P}, 64'd0);
    rst = 1'b0;
    step();

    mult("3x5", 16'd3, 16'd5, 32'h0000000F, -1);
    mult("ffff sq", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, -1);
    mult("8000 sq", 16'h8000, 16'h8000, 32'h40000000, -1);
    mult("zero", 16'h0000, 16'h1234, 32'h00000000, -1);
    mult("identity", 16'h1234, 16'h0001, 32'h00001234, -1);
    mult("ignored start", 16'd7, 16'd9, 32'd63, 5);

    // Back-to-back: start held high through the whole first run.
    A = 16'd10;
    B = 16'd10;
    start = 1'b1;
    step();
    A = 16'h0F0F;
    B = 16'hF0F0;
    wait_done(-1, n, nb);
    check("b2b first latency", 64'(n), 64'(WIDTH));
    check("b2b first P", 64'(P), 64'd100);
    A = 16'h0100;
    B = 16'h0100;
    step();
    start = 1'b0;
    check("b2b busy rises", {63'd0, busy}, 64'd1);
    wait_done(-1, n, nb);
    check("b2b second latency", 64'(n + 1), 64'(WIDTH + 1));
    check("b2b second P", 64'(P), 64'h00010000);
    step();
    check("b2b idle after", {62'd0, busy, done}, 64'd0);

    // Asynchronous reset in the middle of a run.
    A = 16'hFFFF;
    B = 16'hFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("pre-reset busy", {63'd0, busy}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset clears", {30'd0, busy, done, P}, 64'd0);
    step();
    step();
    rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) nb++;
      step();
    end
    check("no done after reset", 64'(nb), 64'd0);
    mult("6x7", 16'd6, 16'd7, 32'd42, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
